// File: rtl/bitstream_word_packer.sv
// Repacks the bit-accumulator's variable byte stream (0..8 MSB-aligned bytes per cycle) into full 64-bit words.
// Optional build macro PACKER_LITTLE_ENDIAN_EN reverses the byte lanes of wr_data/wr_mask.
module bitstream_word_packer #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned BYTE_CNT_W = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     start_addr,
    input  logic [3:0]            in_enable_byte,
    input  logic [63:0]           in_val,
    input  logic                  flush,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [63:0]           wr_data,
    output logic [7:0]            wr_mask,
    output logic [BYTE_CNT_W-1:0] total_bytes,
    output logic                  flush_done,
    output logic                  err
);

    localparam int unsigned WORD_W = 64;
    localparam int unsigned RES_W  = 56;
    localparam int unsigned CAT_W  = WORD_W + RES_W;

    localparam logic [0:0] ST_RUN        = 1'b0;
    localparam logic [0:0] ST_FLUSH_PEND = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [RES_W-1:0]      res_q, res_d;
    logic [2:0]            r_q, r_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [BYTE_CNT_W-1:0] total_q, total_d;
    logic                  err_q, err_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0]     wr_data_q, wr_data_d;
    logic [7:0]            wr_mask_q, wr_mask_d;
    logic                  flush_done_q, flush_done_d;

    logic                  n_over_c;
    logic [3:0]            n_c;
    logic [3:0]            sum_c;
    logic                  full_c;
    logic                  flush_eval_c;
    logic                  go_pend_c;
    logic [WORD_W-1:0]     keep_c;
    logic [CAT_W-1:0]      cat_c;

    // Map a big-endian packed word onto the configured output lane order.
    function automatic logic [WORD_W-1:0] lane_data(input logic [WORD_W-1:0] d);
`ifdef PACKER_LITTLE_ENDIAN_EN
        logic [WORD_W-1:0] r;
        for (int k = 0; k < 8; k++) begin
            r[8*k +: 8] = d[WORD_W-8-8*k +: 8];
        end
        return r;
`else
        return d;
`endif
    endfunction

    function automatic logic [7:0] lane_mask(input logic [7:0] m);
`ifdef PACKER_LITTLE_ENDIAN_EN
        logic [7:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k] = m[7-k];
        end
        return r;
`else
        return m;
`endif
    endfunction

    // Append the new bytes behind the residual bytes; res_q is kept zero beyond R bytes.
    always_comb begin
        n_over_c     = in_enable_byte > 4'd8;
        n_c          = n_over_c ? 4'd8 : in_enable_byte;
        keep_c       = ~({WORD_W{1'b1}} >> {n_c, 3'b000});
        cat_c        = {res_q, {WORD_W{1'b0}}} | ({in_val & keep_c, {RES_W{1'b0}}} >> {r_q, 3'b000});
        sum_c        = {1'b0, r_q} + n_c;
        full_c       = sum_c >= 4'd8;
        flush_eval_c = (state_q == ST_FLUSH_PEND) || (flush && (n_c == 4'd0));
        go_pend_c    = (state_q == ST_RUN) && flush && (n_c != 4'd0);
    end

    always_comb begin
        state_d      = state_q;
        res_d        = res_q;
        r_d          = r_q;
        addr_d       = addr_q;
        total_d      = total_q;
        err_d        = err_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = '0;
        wr_mask_d    = '0;
        flush_done_d = 1'b0;

        if (start) begin
            state_d   = ST_RUN;
            res_d     = '0;
            r_d       = '0;
            addr_d    = start_addr;
            wr_addr_d = start_addr;
            total_d   = '0;
            err_d     = 1'b0;
        end else begin
            total_d = total_q + BYTE_CNT_W'(n_c);
            if (n_over_c) begin
                err_d = 1'b1;
            end
            if (full_c) begin
                // A completed word always wins; a pending flush waits a cycle.
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = lane_data(cat_c[CAT_W-1 -: WORD_W]);
                wr_mask_d = lane_mask(8'hFF);
                addr_d    = addr_q + ADDR_W'(1);
                res_d     = cat_c[RES_W-1:0];
                r_d       = 3'(sum_c - 4'd8);
                if (go_pend_c) begin
                    state_d = ST_FLUSH_PEND;
                end
            end else if (flush_eval_c) begin
                flush_done_d = 1'b1;
                state_d      = ST_RUN;
                res_d        = '0;
                r_d          = '0;
                if (sum_c != 4'd0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = lane_data(cat_c[CAT_W-1 -: WORD_W]);
                    wr_mask_d = lane_mask(8'(8'hFF << (4'd8 - sum_c)));
                    addr_d    = addr_q + ADDR_W'(1);
                end
            end else begin
                res_d = cat_c[CAT_W-1 -: RES_W];
                r_d   = sum_c[2:0];
                if (go_pend_c) begin
                    state_d = ST_FLUSH_PEND;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset_n) begin
        if (reset_n) begin
            state_q      <= ST_RUN;
            res_q        <= '0;
            r_q          <= '0;
            addr_q       <= '0;
            total_q      <= '0;
            err_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_mask_q    <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            r_q          <= r_d;
            addr_q       <= addr_d;
            total_q      <= total_d;
            err_q        <= err_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_mask_q    <= wr_mask_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign wr_mask     = wr_mask_q;
    assign total_bytes = total_q;
    assign flush_done  = flush_done_q;
    assign err         = err_q;

endmodule

// File: doc/bitstream_word_packer.md
Name: bitstream_word_packer

Overview:
- Sits directly downstream of the bit-accumulator stage.
- Consumes its per-cycle output: a byte count (0..8) and a 64-bit value whose valid bytes are MSB-aligned.
- Repacks the irregular byte stream into full 64-bit words and writes them sequentially to the output stream buffer with a word address and byte mask.
- On flush, emits the final partial word and reports the total byte count.

Parameters:
- ADDR_W, 32, width of word address output
- BYTE_CNT_W, 32, width of total byte counter

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous reset, active-high (asserted = 1 clears all state immediately)
- start  in  1  one-cycle pulse; loads start_addr, clears buffer, counters and error
- start_addr  in  ADDR_W  first word address
- in_enable_byte  in  4  number of valid bytes in in_val (0..8)
- in_val  in  64  data; byte k of the stream is bits [63-8k : 56-8k]
- flush  in  1  one-cycle pulse; emit residual bytes as a partial word
- wr_en  out  1  write strobe, one word per cycle
- wr_addr  out  ADDR_W  word address of wr_data
- wr_data  out  64  packed word; first stream byte in [63:56]
- wr_mask  out  8  byte enables; bit 7 corresponds to [63:56]
- total_bytes  out  BYTE_CNT_W  bytes accepted since start
- flush_done  out  1  one-cycle pulse after final partial word (or no-op flush) is issued
- err  out  1  sticky; set when in_enable_byte > 8

Behaviour:
- Reset values: wr_en=0, wr_addr=0, wr_data=0, wr_mask=0, total_bytes=0, flush_done=0, err=0.
- Reset also clears the residual buffer, residual count and FSM (to RUN). Reset mid-operation discards residual bytes silently.
- Internal state: residual buffer of 7 bytes, residual count R in 0..7, FSM {RUN, FLUSH_PEND}.
- No backpressure. An input with in_enable_byte>0 is accepted every cycle.
- Append, with n = in_enable_byte:
  - The new bytes go after the R residual bytes. S = R + n, range 0..15.
  - If S >= 8: in the next cycle wr_en=1, wr_data = first 8 bytes, wr_mask=8'hFF, and wr_addr = current address, which then increments by 1. New R = S-8.
  - If S < 8: no write; new R = S.
- Latency: the write appears 1 cycle after the input that completes the word. All outputs are registered.
- Count and error:
  - total_bytes += n each accepting cycle. It wraps modulo 2^BYTE_CNT_W.
  - n in 9..15 is treated as n=8 and sets err.
- Flush with in_enable_byte==0:
  - If R>0: next cycle wr_en=1, wr_data = residual bytes MSB-aligned with zero padding, wr_mask = top R bits set (R=3 gives 8'hE0). Address increments; R becomes 0.
  - flush_done pulses in the same cycle as that write. If R==0: no write, flush_done pulses next cycle.
- Flush coinciding with data:
  - The data is appended first (possible full-word write as above).
  - FSM goes to FLUSH_PEND; the next cycle performs the flush on the new R.
- FLUSH_PEND:
  - Data arriving in this cycle is appended before the flush is evaluated.
  - Full-word priority: if S >= 8 the full word is written and FLUSH_PEND is held.
  - Otherwise the partial flush is issued and the FSM returns to RUN.
- Flush while already in FLUSH_PEND is absorbed; no second flush_done.
- start has highest priority:
  - Overrides data and flush in the same cycle.
  - wr_addr=start_addr, R=0, total_bytes=0, err=0, FSM=RUN, no write issued.
- wr_en is low in every cycle with no write. wr_data and wr_mask are 0 when wr_en=0.
- wr_addr wraps modulo 2^ADDR_W.

Optional Feature:
- Macro: PACKER_LITTLE_ENDIAN_EN
- Defined: the byte lane order of wr_data and wr_mask is reversed. The first stream byte goes to [7:0] and mask bit 0; a partial word with R=3 gives mask 8'h07.
- Undefined: big-endian lanes as above (the first stream byte goes to [63:56]).
- Input interpretation, counters and timing are identical in both builds.

Test Plan:
- start_addr=0x100; inputs n=3 (AABBCC…), n=5 (DDEEFF1122…) on consecutive cycles -> one write, wr_addr=0x100, wr_data=AABBCCDDEEFF1122, wr_mask=FF, total_bytes=8, R=0.
- Eight consecutive n=8 inputs -> eight back-to-back writes, addresses 0x100..0x107, mask FF each, total_bytes=64.
- n=7 then n=8 then flush -> writes: word1 (7+1 bytes, FF), then partial with 7 bytes, mask FE, zero padding in [7:0], flush_done in the same cycle, total_bytes=15.
- R=5 plus data n=6 with flush in the same cycle -> full word in cycle+1; FLUSH_PEND; partial with R=3, mask E0, flush_done in cycle+2.
- Flush with R=0 -> no wr_en, flush_done 1 cycle later; in_enable_byte=12 -> treated as 8 bytes, err=1 until next start.
- Reset asserted while R=4 mid-stream -> all outputs 0 immediately (asynchronous); after release, flush -> no write, only flush_done.
